fetch_pc_gen: RTL and testbench

Fetch-stage next-PC generator sitting directly upstream of the branch target buffer. Holds the fetch PC and drives the BTB read index each cycle. One cycle later it consumes the BTB prediction (`validRead`, `targetAddress`) and selects the next fetch PC from commit redirect, stall hold, predicted target or sequential PC+4. It presents each fetched PC, with its prediction, to decode.

---
 rtl/fetch_pc_gen.sv | 175 +++++++++++++++++
 tb/tb_fetch_pc_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: holds the fetch PC, indexes the BTB and
// selects the next PC. Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_pc_gen #(
    parameter int unsigned   WIDTH    = 31,
    parameter int unsigned   B_WIDTH  = 7,
    parameter logic [WIDTH:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               resetN,
    output logic [B_WIDTH:0]   PC,
    input  logic               validRead,
    input  logic [WIDTH:0]     targetAddress,
    input  logic               redirect,
    input  logic [WIDTH:0]     redirectPC,
    input  logic               stall,
    output logic               fetchValid,
    output logic [WIDTH:0]     fetchPC,
    output logic               predTaken,
    output logic [WIDTH:0]     predTarget,
    output logic [15:0]        redirectCount,
    output logic [15:0]        bubbleCount
);

    localparam int unsigned PW = WIDTH + 1;
    localparam int unsigned CW = 16;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state;
    state_t          stateNext;

    logic [WIDTH:0]  pcF0;
    logic            f0Valid;
    logic [WIDTH:0]  pcF1;
    logic            f1Valid;
    logic            holdTaken;
    logic [WIDTH:0]  holdTarget;

    // Per-edge decode of the next-PC selection rules
    logic            effTaken;
    logic [WIDTH:0]  effTarget;
    logic            doRedirect;
    logic            doHold;
    logic            doTaken;
    logic            doSeq;
    logic            captureHold;
    logic            squash;

    // State register
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic: redirect always returns to RUN; a stalled valid F1 holds
    always_comb begin
        stateNext = state;
        unique case (state)
            RUN: begin
                if (!redirect && stall && f1Valid) begin
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    stateNext = RUN;
                end
            end
            default: stateNext = RUN;
        endcase
    end

    // Output / rule decode; the BTB output is only trusted while not holding
    always_comb begin
        effTaken    = validRead;
        effTarget   = targetAddress;
        doRedirect  = 1'b0;
        doHold      = 1'b0;
        doTaken     = 1'b0;
        doSeq       = 1'b0;
        captureHold = 1'b0;
        squash      = 1'b0;

        if (state == HOLD) begin
            effTaken  = holdTaken;
            effTarget = holdTarget;
        end

        if (redirect) begin
            doRedirect = 1'b1;
        end else if (stall && f1Valid) begin
            doHold      = 1'b1;
            captureHold = (state == RUN);
        end else if (f1Valid && effTaken) begin
            doTaken = 1'b1;
        end else begin
            doSeq = 1'b1;
        end

        squash     = doRedirect | doTaken;
        predTaken  = f1Valid & effTaken;
        predTarget = effTarget;
    end

    assign PC         = pcF0[B_WIDTH+2:2];
    assign fetchValid = f1Valid;
    assign fetchPC    = pcF1;

    // F0/F1 pipeline registers
    always_ff @(posedge clk) begin
        if (!resetN) begin
            pcF0    <= RESET_PC;
            f0Valid <= 1'b1;
            pcF1    <= '0;
            f1Valid <= 1'b0;
        end else if (doRedirect) begin
            pcF0    <= redirectPC;
            f1Valid <= 1'b0;
        end else if (doTaken) begin
            // Sequential PC already in F0 is dropped: one bubble
            pcF0    <= effTarget;
            f1Valid <= 1'b0;
        end else if (doSeq) begin
            pcF1    <= pcF0;
            f1Valid <= f0Valid;
            pcF0    <= pcF0 + PW'(4);
        end
    end

    // Prediction captured on entry to HOLD, since the BTB moves on to pcF0
    always_ff @(posedge clk) begin
        if (!resetN) begin
            holdTaken  <= 1'b0;
            holdTarget <= '0;
        end else if (captureHold) begin
            holdTaken  <= validRead;
            holdTarget <= targetAddress;
        end
    end

`ifdef FETCH_PERF_EN
    logic [CW-1:0] redirectCnt;
    logic [CW-1:0] bubbleCnt;

    // Saturating perf counters
    always_ff @(posedge clk) begin
        if (!resetN) begin
            redirectCnt <= '0;
            bubbleCnt   <= '0;
        end else begin
            if (doRedirect && (redirectCnt != {CW{1'b1}})) begin
                redirectCnt <= redirectCnt + CW'(1);
            end
            if (squash && (bubbleCnt != {CW{1'b1}})) begin
                bubbleCnt <= bubbleCnt + CW'(1);
            end
        end
    end

    assign redirectCount = redirectCnt;
    assign bubbleCount   = bubbleCnt;
`else
    logic unusedSquash;
    assign unusedSquash  = squash;
    assign redirectCount = '0;
    assign bubbleCount   = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed scenarios followed by random
// stimulus, all compared against a behavioural fetch model.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        resetN;
    logic [7:0]  PC;
    logic        validRead;
    logic [31:0] targetAddress;
    logic        redirect;
    logic [31:0] redirectPC;
    logic        stall;
    logic        fetchValid;
    logic [31:0] fetchPC;
    logic        predTaken;
    logic [31:0] predTarget;
    logic [15:0] redirectCount;
    logic [15:0] bubbleCount;

    int errors = 0;
    int checks = 0;

    fetch_pc_gen #(.WIDTH(31), .B_WIDTH(7), .RESET_PC(32'h100)) dut (
        .clk(clk), .resetN(resetN), .PC(PC),
        .validRead(validRead), .targetAddress(targetAddress),
        .redirect(redirect), .redirectPC(redirectPC), .stall(stall),
        .fetchValid(fetchValid), .fetchPC(fetchPC),
        .predTaken(predTaken), .predTarget(predTarget),
        .redirectCount(redirectCount), .bubbleCount(bubbleCount)
    );

    always #5 clk = ~clk;

    // Reference model: the fetch address, the PC on offer to decode, and a
    // remembered prediction while decode refuses it.
    logic [31:0] mNext;
    logic [31:0] mShown;
    logic        mShownValid;
    logic        mFrozen;
    logic        mFrozenTaken;
    logic [31:0] mFrozenTarget;
    int          mRedirects;
    int          mBubbles;

    function automatic logic modelTaken();
        return mFrozen ? mFrozenTaken : validRead;
    endfunction

    function automatic logic [31:0] modelTarget();
        return mFrozen ? mFrozenTarget : targetAddress;
    endfunction

    task automatic modelEdge();
        logic        tk;
        logic [31:0] tg;
        tk = modelTaken();
        tg = modelTarget();
        if (!resetN) begin
            mNext = 32'h100; mShown = 32'h0; mShownValid = 1'b0;
            mFrozen = 1'b0; mFrozenTaken = 1'b0; mFrozenTarget = 32'h0;
            mRedirects = 0; mBubbles = 0;
        end else if (redirect) begin
            mNext = redirectPC; mShownValid = 1'b0; mFrozen = 1'b0;
            mRedirects = (mRedirects < 65535) ? mRedirects + 1 : 65535;
            mBubbles   = (mBubbles < 65535) ? mBubbles + 1 : 65535;
        end else if (stall && mShownValid) begin
            if (!mFrozen) begin
                mFrozen = 1'b1; mFrozenTaken = validRead; mFrozenTarget = targetAddress;
            end
        end else if (mShownValid && tk) begin
            mNext = tg; mShownValid = 1'b0; mFrozen = 1'b0;
            mBubbles = (mBubbles < 65535) ? mBubbles + 1 : 65535;
        end else begin
            mShown = mNext; mShownValid = 1'b1; mNext = mNext + 32'd4; mFrozen = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model once inputs have settled
    task automatic checkAll();
        logic [31:0] idx;
        #1;
        idx = {24'h0, mNext[9:2]};
        chk("fetchValid", {31'h0, fetchValid}, {31'h0, mShownValid});
        if (mShownValid) chk("fetchPC", fetchPC, mShown);
        chk("predTaken", {31'h0, predTaken}, {31'h0, mShownValid & modelTaken()});
        chk("predTarget", predTarget, modelTarget());
        chk("PC", {24'h0, PC}, idx);
`ifdef FETCH_PERF_EN
        chk("redirectCount", {16'h0, redirectCount}, 32'(mRedirects));
        chk("bubbleCount", {16'h0, bubbleCount}, 32'(mBubbles));
`else
        chk("redirectCount", {16'h0, redirectCount}, 32'h0);
        chk("bubbleCount", {16'h0, bubbleCount}, 32'h0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    initial begin
        resetN = 1'b0; validRead = 1'b0; targetAddress = 32'h0;
        redirect = 1'b0; redirectPC = 32'h0; stall = 1'b0;
        @(negedge clk);
        tick();

        // Reset state
        checkAll();
        chk("rst_fetchValid", {31'h0, fetchValid}, 32'h0);
        chk("rst_PC", {24'h0, PC}, 32'h40);

        // Sequential fetch from RESET_PC
        resetN = 1'b1;
        tick(); checkAll();
        chk("seq0", fetchPC, 32'h100);
        chk("seq0_idx", {24'h0, PC}, 32'h41);
        tick();
        validRead = 1'b1; targetAddress = 32'h200;
        checkAll();
        chk("br_pc", fetchPC, 32'h104);
        chk("br_taken", {31'h0, predTaken}, 32'h1);

        // Stall while a taken prediction sits in F1, BTB output churning
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            validRead = 1'(i % 2); targetAddress = 32'h500 + 32'(i * 16);
            checkAll();
            chk("hold_pc", fetchPC, 32'h104);
            chk("hold_tgt", predTarget, 32'h200);
        end
        stall = 1'b0; validRead = 1'b0; targetAddress = 32'h0;
        checkAll();
        tick(); checkAll();
        chk("bubble", {31'h0, fetchValid}, 32'h0);
        tick(); checkAll();
        chk("target", fetchPC, 32'h200);
        tick(); checkAll();
        chk("target4", fetchPC, 32'h204);

        // Redirect beats stall
        redirect = 1'b1; redirectPC = 32'h3F0; stall = 1'b1;
        checkAll();
        tick();
        redirect = 1'b0; stall = 1'b0;
        checkAll();
        chk("redir_bubble", {31'h0, fetchValid}, 32'h0);
        tick(); checkAll();
        chk("redir_pc", fetchPC, 32'h3F0);

        // PC wrap at the top of the address space
        redirect = 1'b1; redirectPC = 32'hFFFF_FFFC;
        checkAll(); tick();
        redirect = 1'b0;
        checkAll(); tick(); checkAll();
        chk("wrap_hi", fetchPC, 32'hFFFF_FFFC);
        chk("wrap_idx", {24'h0, PC}, 32'h0);
        tick(); checkAll();
        chk("wrap_lo", fetchPC, 32'h0);

        // Reset in HOLD with redirect pending
        stall = 1'b1; validRead = 1'b1; targetAddress = 32'h700;
        checkAll(); tick(); checkAll();
        resetN = 1'b0; redirect = 1'b1; validRead = 1'b0; targetAddress = 32'h0;
        tick();
        checkAll();
        chk("mid_rst_valid", {31'h0, fetchValid}, 32'h0);
        chk("mid_rst_idx", {24'h0, PC}, 32'h40);
        resetN = 1'b1; redirect = 1'b0; stall = 1'b0;
        tick(); checkAll();
        chk("restart", fetchPC, 32'h100);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            resetN        = ($urandom_range(0, 99) != 0);
            redirect      = ($urandom_range(0, 15) == 0);
            redirectPC    = $urandom;
            stall         = ($urandom_range(0, 3) == 0);
            validRead     = ($urandom_range(0, 3) == 0);
            targetAddress = $urandom;
            checkAll();
            tick();
        end
        checkAll();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
